// File: rtl/seq_gen.sv
// Serial pattern transmitter: latches a parallel pattern on start and shifts it out LSB-first
// with repetition and an optional idle gap. Define SEQ_GEN_PARITY_EN to append an even-parity bit per frame.
module seq_gen #(
    parameter int WIDTH      = 12,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       rep_cnt,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_GEN_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);
    localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] latched, latched_nxt;
    logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [3:0]       rep_left, rep_left_nxt;
    logic [7:0]       gap_cnt, gap_cnt_nxt;
    logic             ser_out_nxt, ser_valid_nxt, busy_nxt, done_nxt;
    logic             reload;
`ifdef SEQ_GEN_PARITY_EN
    logic             par, par_nxt;
`endif

    // Outputs are computed one cycle ahead here and registered below, so they show the
    // current bit with no combinational path from inputs.
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        latched_nxt   = latched;
        bit_cnt_nxt   = bit_cnt;
        rep_left_nxt  = rep_left;
        gap_cnt_nxt   = gap_cnt;
        ser_out_nxt   = 1'b0;
        ser_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        reload        = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
        par_nxt       = par;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    latched_nxt   = pattern;
                    rep_left_nxt  = rep_cnt;
                    shreg_nxt     = pattern >> 1;
                    ser_out_nxt   = pattern[0];
                    ser_valid_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                    bit_cnt_nxt   = CW'(1);
                    state_nxt     = SHIFT;
`ifdef SEQ_GEN_PARITY_EN
                    par_nxt       = ^pattern;
`endif
                end
            end
            SHIFT: begin
                if (bit_cnt < CW'(FRAME)) begin
                    busy_nxt      = 1'b1;
                    ser_valid_nxt = 1'b1;
                    ser_out_nxt   = shreg[0];
`ifdef SEQ_GEN_PARITY_EN
                    if (bit_cnt == CW'(WIDTH)) ser_out_nxt = par;
`endif
                    shreg_nxt     = shreg >> 1;
                    bit_cnt_nxt   = bit_cnt + CW'(1);
                end else if (rep_left == 4'd0) begin
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
                    bit_cnt_nxt = '0;
                end else if (GAP_CYCLES > 0) begin
                    state_nxt   = GAP;
                    busy_nxt    = 1'b1;
                    gap_cnt_nxt = GAP_LAST;
                    bit_cnt_nxt = '0;
                end else begin
                    reload = 1'b1;
                end
            end
            GAP: begin
                busy_nxt = 1'b1;
                if (gap_cnt == 8'd0) reload = 1'b1;
                else gap_cnt_nxt = gap_cnt - 8'd1;
            end
            default: state_nxt = IDLE;
        endcase

        // A reload drives bit 0 of the next repetition in the same cycle, so no bubble appears.
        if (reload) begin
            shreg_nxt     = latched >> 1;
            ser_out_nxt   = latched[0];
            ser_valid_nxt = 1'b1;
            busy_nxt      = 1'b1;
            bit_cnt_nxt   = CW'(1);
            rep_left_nxt  = rep_left - 4'd1;
            state_nxt     = SHIFT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            latched   <= '0;
            bit_cnt   <= '0;
            rep_left  <= '0;
            gap_cnt   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            latched   <= latched_nxt;
            bit_cnt   <= bit_cnt_nxt;
            rep_left  <= rep_left_nxt;
            gap_cnt   <= gap_cnt_nxt;
            ser_out   <= ser_out_nxt;
            ser_valid <= ser_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
`ifdef SEQ_GEN_PARITY_EN
            par       <= par_nxt;
`endif
        end
    end

endmodule
